mag_cmp_arbiter: RTL and testbench
==================================

Name: mag_cmp_arbiter

Overview:
- Shares one 4-bit magnitude comparator among NREQ requesters using round-robin arbitration.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- The block grants one requester, latches its operands, runs the compare and returns a tagged gt/eq/lt result on a single response channel with backpressure.
- Sits between the comparator datapath and the client blocks that need magnitude decisions.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width in bits
- IDW, 2, response ID width; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_a  input  NREQ*W  packed operand A; requester i uses bits [i*W +: W]
- req_b  input  NREQ*W  packed operand B, same packing as req_a
- req_ready  output  NREQ  one-hot grant/accept pulse
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  IDW  index of the requester being answered
- rsp_gt  output  1  A > B
- rsp_eq  output  1  A == B
- rsp_lt  output  1  A < B

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_gt=0, rsp_eq=0, rsp_lt=0.
  - Latched operands cleared to 0.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, with wrap-around.
  - Assert req_ready for that bit only, combinationally in the same cycle. The transfer occurs when req_valid && req_ready.
  - Latch that requester's A, B and its index; go to CMP.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- CMP:
  - The latched operands drive the comparator.
  - Register gt/eq/lt and the ID into the rsp_* outputs, set rsp_valid=1, go to RESP.
  - rr_ptr becomes (granted index + 1) mod NREQ.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid && rsp_ready: clear rsp_valid next cycle and go to IDLE.
  - No bypass from RESP to a new grant. Minimum interval is 3 cycles per transaction.
- Latency: grant cycle to rsp_valid is exactly 2 clock edges.
- Result encoding: exactly one of gt/eq/lt is 1 whenever rsp_valid=1. Operands are compared as unsigned W-bit values.
- req_ready is 0 in CMP and RESP. Requests that arrive meanwhile wait; they are never dropped.
- A requester may drop req_valid before it is granted; nothing is latched for it.
- Fairness: a continuously requesting client is granted within NREQ transactions.
- If rsp_ready is held low indefinitely, the block stalls in RESP and grants nothing.
- Reset mid-transaction returns to IDLE immediately. The in-flight result is lost and rsp_valid drops asynchronously.

Optional Feature:
- Macro: MAG_CMP_ARB_STATS_EN.
- When defined:
  - Adds output stat_done (16 bits): count of completed response handshakes, saturating at 16'hFFFF.
  - Adds output stat_eq (16 bits): count of completed handshakes with rsp_eq=1, saturating at 16'hFFFF.
  - Adds input stat_clr (1 bit): synchronous clear of both counters. If stat_clr coincides with a handshake, the counter becomes 0.
  - Both counters reset to 0.
- When undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Package mag_cmp_pkg holds:
  - the state typedef (IDLE/CMP/RESP);
  - the result encoding constants CMP_GT, CMP_EQ, CMP_LT;
  - the default W.
- One natural sub-module: mag_cmp_core, a purely combinational W-bit unsigned comparator (inputs a, b; outputs gt, eq, lt). It is instantiated once and is the only place the compare is implemented.
- The round-robin pick stays inline in the arbiter.

Test Plan:
- Single request: req_valid=4'b0001, A=4'd1, B=4'd4.
  -> req_ready=4'b0001 for one cycle.
  -> Two edges later: rsp_valid=1, rsp_id=0, rsp_lt=1.
- Greater and equal: requester 2 with A=4'd5, B=4'd4 -> rsp_gt=1, rsp_id=2. Then A=4'd3, B=4'd3 -> rsp_eq=1.
- Round-robin: all four requesters valid continuously, with rsp_ready=1.
  -> Grant order is 0,1,2,3,0.
  -> Each grant is spaced 3 cycles apart.
- Backpressure: requester 1 with A=4'd1, B=4'd12, rsp_ready=0 for 5 cycles.
  -> rsp_valid, rsp_id=1 and rsp_lt=1 stay stable.
  -> req_ready stays 0 throughout.
  -> After rsp_ready=1, the next grant comes 1 cycle after the handshake.
- Reset mid-operation: assert rst_n=0 while in CMP with A=4'd3, B=4'd4.
  -> All outputs go to 0 immediately.
  -> After release, the first grant goes to the lowest valid index (rr_ptr=0).
- Stats (with MAG_CMP_ARB_STATS_EN): complete 3 transactions, one of them equal.
  -> stat_done=3, stat_eq=1.
  -> Pulse stat_clr -> both counters read 0.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared types and constants for the round-robin magnitude-compare arbiter.
package mag_cmp_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  // One-hot result encoding, ordered {gt, eq, lt}
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/mag_cmp_core.sv
// Purely combinational unsigned W-bit magnitude comparator.
// Exactly one of gt/eq/lt is high for any input pair.
module mag_cmp_core
  import mag_cmp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  logic [2:0] res;

  // Single compare producing the one-hot {gt, eq, lt} code
  always_comb begin
    if (a > b)       res = CMP_GT;
    else if (a == b) res = CMP_EQ;
    else             res = CMP_LT;
  end

  assign {gt, eq, lt} = res;

endmodule

// File: rtl/mag_cmp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Optional statistics counters are enabled with `define MAG_CMP_ARB_STATS_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | searching for a valid requester from rr_ptr; grant is comb.
// CMP   | latched operands drive the comparator; result is registered
// RESP  | response held on rsp_* until consumer accepts it
module mag_cmp_arbiter
  import mag_cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_gt,
  output logic              rsp_eq,
  output logic              rsp_lt
`ifdef MAG_CMP_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_done,
  output logic [15:0]       stat_eq
`endif
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick_idx, hi_idx, lo_idx;
  logic           pick_found, hi_found, lo_found;
  logic [W-1:0]   sel_a, sel_b;
  logic [W-1:0]   op_a, op_b;
  logic [IDW-1:0] op_id;
  logic           cmp_gt, cmp_eq, cmp_lt;
  logic           grant;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(k);
        if (k >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(k);
        end
      end
    end
    pick_found = lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Mux the picked requester's operand pair out of the packed buses
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == pick_idx) begin
        sel_a = req_a[k*W +: W];
        sel_b = req_b[k*W +: W];
      end
    end
  end

  assign grant = (state == IDLE) && pick_found;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; RESP never bypasses straight to a new grant
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = CMP;
      CMP:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot grant, only in IDLE; forced low while reset is asserted
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = rst_n && grant && (IDW'(k) == pick_idx);
    end
  end

  // Capture the granted requester's operands and index at the transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
    end else if (grant) begin
      op_a  <= sel_a;
      op_b  <= sel_b;
      op_id <= pick_idx;
    end
  end

  mag_cmp_core #(.W(W)) u_core (
    .a  (op_a),
    .b  (op_b),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  // Register the result in CMP, advance the pointer, release on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
      rr_ptr    <= '0;
    end else if (state == CMP) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_gt    <= cmp_gt;
      rsp_eq    <= cmp_eq;
      rsp_lt    <= cmp_lt;
      rr_ptr    <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef MAG_CMP_ARB_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid && rsp_ready;

  // Saturating handshake counters; clear wins over a coincident handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done <= '0;
      stat_eq   <= '0;
    end else if (stat_clr) begin
      stat_done <= '0;
      stat_eq   <= '0;
    end else if (rsp_hs) begin
      if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
      if (rsp_eq && stat_eq != 16'hFFFF) stat_eq <= stat_eq + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mag_cmp_arbiter.sv
// Self-checking bench for mag_cmp_arbiter with a behavioural round-robin model.
module tb_mag_cmp_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic        rsp_gt, rsp_eq, rsp_lt;
`ifdef MAG_CMP_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_done, stat_eq;
`endif

  int checks = 0;
  int failures = 0;
  int mdl_rr = 0;
  int cyc = 0;

  mag_cmp_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt)
`ifdef MAG_CMP_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_done (stat_done),
    .stat_eq   (stat_eq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: first requester at or after the pointer, wrapping around
  function automatic int mdl_pick(input logic [3:0] v, input int rr);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (rr + i) % NREQ;
      if (((v >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] opnd(input logic [15:0] p, input int idx);
    return 4'(p >> (4 * idx));
  endfunction

  function automatic logic [15:0] pk(input logic [3:0] x0, input logic [3:0] x1,
                                     input logic [3:0] x2, input logic [3:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = -1;
    for (int n = 0; n < 12 && !ok; n++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        ok = 1'b1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Drives one request through grant, CMP and the first RESP cycle; observes only
  task automatic txn(input logic [3:0] mask, input logic [15:0] pa, input logic [15:0] pb,
                     input logic [3:0] after_mask, output bit ok, output int g,
                     output logic [3:0] rdy_g, output logic [3:0] rdy_cmp, output logic rv_cmp,
                     output logic rv, output logic [1:0] id,
                     output logic gt, output logic eq, output logic lt);
    req_valid = mask;
    req_a     = pa;
    req_b     = pb;
    wait_grant(ok, g);
    rdy_g = req_ready;
    if (!ok) begin
      req_valid = '0;
      return;
    end
    step();
    req_valid = after_mask;
    @(negedge clk);
    rdy_cmp = req_ready;
    rv_cmp  = rsp_valid;
    step();
    @(negedge clk);
    rv = rsp_valid;
    id = rsp_id;
    gt = rsp_gt;
    eq = rsp_eq;
    lt = rsp_lt;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b0101;
    #12;
    checks++;
    if (req_ready !== 4'd0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== 6'd0) begin
      failures++;
      $display("FAIL reset_rsp got=%b exp=000000", {rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt});
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mdl_rr = 0;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int prev_cyc;
    bit ok;
    int g, ge;
    logic [3:0] a[4], b[4];
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 4'($urandom_range(0, 15));
      b[i] = 4'($urandom_range(0, 15));
    end
    req_a = pk(a[0], a[1], a[2], a[3]);
    req_b = pk(b[0], b[1], b[2], b[3]);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      ge = mdl_pick(4'b1111, mdl_rr);
      wait_grant(ok, g);
      checks++;
      if (!ok) begin failures++; $display("FAIL rr_timeout grant %0d not observed", n); req_valid = '0; return; end
      checks++;
      if (g !== ge || g !== exp_order[n]) begin
        failures++;
        $display("FAIL rr_order n=%0d got=%0d exp=%0d", n, g, ge);
      end
      if (n > 0) begin
        checks++;
        if (cyc - prev_cyc !== 3) begin failures++; $display("FAIL rr_spacing got=%0d exp=3", cyc - prev_cyc); end
      end
      prev_cyc = cyc;
      step();
      @(negedge clk);
      step();
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id} !== {1'b1, 2'(ge)} ||
          {rsp_gt, rsp_eq, rsp_lt} !== {a[ge] > b[ge], a[ge] == b[ge], a[ge] < b[ge]}) begin
        failures++;
        $display("FAIL rr_rsp got v=%b id=%0d gel=%b%b%b exp id=%0d", rsp_valid, rsp_id,
                 rsp_gt, rsp_eq, rsp_lt, ge);
      end
      mdl_rr = (ge + 1) % NREQ;
      if (n == 4) req_valid = '0;
      step();
    end
  endtask

  task automatic test_single();
    bit ok; int g;
    logic [3:0] rg, rc; logic rvc, rv, gt, eq, lt; logic [1:0] id;
    txn(4'b0001, pk(4'd1, 4'd0, 4'd0, 4'd0), pk(4'd4, 4'd0, 4'd0, 4'd0), 4'b0000,
        ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    checks++;
    if (rg !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", rg); end
    checks++;
    if (rc !== 4'b0000 || rvc !== 1'b0) begin failures++; $display("FAIL single_cmp rdy=%b v=%b exp 0000/0", rc, rvc); end
    checks++;
    if ({rv, id, gt, eq, lt} !== {1'b1, 2'd0, 3'b001}) begin
      failures++;
      $display("FAIL single_rsp got=%b exp=100001", {rv, id, gt, eq, lt});
    end
    mdl_rr = 1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", rsp_valid); end
    step();
  endtask

  task automatic test_gt_eq();
    bit ok; int g;
    logic [3:0] rg, rc; logic rvc, rv, gt, eq, lt; logic [1:0] id;
    txn(4'b0100, pk(4'd0, 4'd0, 4'd5, 4'd0), pk(4'd0, 4'd0, 4'd4, 4'd0), 4'b0000,
        ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    checks++;
    if ({rg, rv, id, gt, eq, lt} !== {4'b0100, 1'b1, 2'd2, 3'b100}) begin
      failures++;
      $display("FAIL gt_rsp got rdy=%b v=%b id=%0d gel=%b%b%b exp 0100/1/2/100", rg, rv, id, gt, eq, lt);
    end
    txn(4'b0100, pk(4'd0, 4'd0, 4'd3, 4'd0), pk(4'd0, 4'd0, 4'd3, 4'd0), 4'b0000,
        ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    checks++;
    if ({rg, rv, id, gt, eq, lt} !== {4'b0100, 1'b1, 2'd2, 3'b010}) begin
      failures++;
      $display("FAIL eq_rsp got rdy=%b v=%b id=%0d gel=%b%b%b exp 0100/1/2/010", rg, rv, id, gt, eq, lt);
    end
    mdl_rr = 3;
  endtask

  task automatic test_random();
    bit ok; int g, ge;
    logic [3:0] rg, rc, mask, ea, eb; logic rvc, rv, gt, eq, lt; logic [1:0] id;
    logic [15:0] pa, pb;
    for (int n = 0; n < 16; n++) begin
      mask = 4'($urandom_range(1, 15));
      pa = 16'($urandom);
      pb = 16'($urandom);
      ge = mdl_pick(mask, mdl_rr);
      ea = opnd(pa, ge);
      eb = opnd(pb, ge);
      txn(mask, pa, pb, 4'b0000, ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
      checks++;
      if (!ok || rg !== 4'(1 << ge)) begin
        failures++;
        $display("FAIL rand_grant n=%0d mask=%b got=%b exp=%b", n, mask, rg, 4'(1 << ge));
      end
      checks++;
      if ({rv, id, gt, eq, lt} !== {1'b1, 2'(ge), ea > eb, ea == eb, ea < eb}) begin
        failures++;
        $display("FAIL rand_rsp n=%0d got v=%b id=%0d gel=%b%b%b exp id=%0d a=%0d b=%0d",
                 n, rv, id, gt, eq, lt, ge, ea, eb);
      end
      mdl_rr = (ge + 1) % NREQ;
    end
  endtask

  task automatic test_backpressure();
    bit ok; int g, ge;
    logic [3:0] rg, rc; logic rvc, rv, gt, eq, lt; logic [1:0] id;
    logic [15:0] pa, pb;
    pa = pk(4'd0, 4'd1, 4'd0, 4'd9);
    pb = pk(4'd0, 4'd12, 4'd0, 4'd2);
    rsp_ready = 1'b0;
    txn(4'b0010, pa, pb, 4'b1000, ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    checks++;
    if ({rg, rv, id, gt, eq, lt} !== {4'b0010, 1'b1, 2'd1, 3'b001}) begin
      failures++;
      $display("FAIL bp_first got rdy=%b v=%b id=%0d gel=%b%b%b exp 0010/1/1/001", rg, rv, id, gt, eq, lt);
    end
    mdl_rr = 2;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {4'b0000, 1'b1, 2'd1, 3'b001}) begin
        failures++;
        $display("FAIL bp_hold n=%0d got rdy=%b v=%b id=%0d gel=%b%b%b", n, req_ready, rsp_valid,
                 rsp_id, rsp_gt, rsp_eq, rsp_lt);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    ge = mdl_pick(4'b1000, mdl_rr);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'(1 << ge) || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_grant got rdy=%b v=%b exp rdy=%b v=0", req_ready, rsp_valid, 4'(1 << ge));
    end
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'(ge), 3'b100}) begin
      failures++;
      $display("FAIL bp_second got v=%b id=%0d gel=%b%b%b exp 1/%0d/100", rsp_valid, rsp_id,
               rsp_gt, rsp_eq, rsp_lt, ge);
    end
    mdl_rr = (ge + 1) % NREQ;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok; int g;
    logic [3:0] rg, rc; logic rvc, rv, gt, eq, lt; logic [1:0] id;
    logic [15:0] pa, pb;
    pa = pk(4'd0, 4'd3, 4'd3, 4'd0);
    pb = pk(4'd0, 4'd4, 4'd4, 4'd0);
    req_a = pa;
    req_b = pb;
    req_valid = 4'b0110;
    wait_grant(ok, g);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_grant no grant observed, exp one"); end
    step();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== 10'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got rdy=%b v=%b id=%0d gel=%b%b%b exp all 0", req_ready,
               rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mdl_rr = 0;
    txn(4'b0110, pa, pb, 4'b0000, ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    checks++;
    if ({rg, rv, id, gt, eq, lt} !== {4'(1 << mdl_pick(4'b0110, 0)), 1'b1, 2'd1, 3'b001}) begin
      failures++;
      $display("FAIL rstmid_after got rdy=%b v=%b id=%0d gel=%b%b%b exp 0010/1/1/001", rg, rv, id, gt, eq, lt);
    end
    mdl_rr = 2;
  endtask

`ifdef MAG_CMP_ARB_STATS_EN
  task automatic test_stats();
    bit ok; int g;
    logic [3:0] rg, rc; logic rvc, rv, gt, eq, lt; logic [1:0] id;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    txn(4'b0001, pk(4'd2, 4'd0, 4'd0, 4'd0), pk(4'd7, 4'd0, 4'd0, 4'd0), 4'b0, ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    txn(4'b0010, pk(4'd0, 4'd6, 4'd0, 4'd0), pk(4'd0, 4'd6, 4'd0, 4'd0), 4'b0, ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    txn(4'b0100, pk(4'd0, 4'd0, 4'd9, 4'd0), pk(4'd0, 4'd0, 4'd1, 4'd0), 4'b0, ok, g, rg, rc, rvc, rv, id, gt, eq, lt);
    @(negedge clk);
    checks++;
    if (stat_done !== 16'd3 || stat_eq !== 16'd1) begin
      failures++;
      $display("FAIL stats_count got done=%0d eq=%0d exp 3/1", stat_done, stat_eq);
    end
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (stat_done !== 16'd0 || stat_eq !== 16'd0) begin
      failures++;
      $display("FAIL stats_clear got done=%0d eq=%0d exp 0/0", stat_done, stat_eq);
    end
    step();
    mdl_rr = 3;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_gt_eq();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef MAG_CMP_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
